// File: rtl/rst_seq.sv
// rst_seq: staged reset release sequencer.
// Waits for a synchronised clock-source lock, holds every channel in reset
// for HOLD_CYCLES, then releases channels 0..NUM_OUT-1 one by one,
// STAGE_GAP cycles apart. Losing lock or a software reset request aborts
// the sequence and puts every channel back into reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_WAIT  | all channels in reset, waiting for lock_s=1 with sw_rst_i=0
// S_HOLD  | lock seen, all channels still in reset for HOLD_CYCLES
// S_STAGE | channels being released one per STAGE_GAP cycles
// S_RUN   | every channel released, done_o high

module rst_seq #(
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               lock_i,
  input  logic               sw_rst_i,
  output logic [NUM_OUT-1:0] rst_o,
  output logic               done_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int STW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CW-1:0]  HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  GAP_LAST   = CW'(STAGE_GAP - 1);
  // Stage index at which the release of the next channel is the final one.
  localparam logic [STW-1:0] LAST_STAGE = STW'((NUM_OUT > 1) ? (NUM_OUT - 2) : 0);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_HOLD  = 2'd1,
    S_STAGE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [STW-1:0]         r_stage;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [NUM_OUT-1:0]     r_rst;
  logic                   r_done;

  logic w_lock_s;
  logic w_abort;

  assign w_lock_s = r_sync[SYNC_STAGES-1];
  // sw_rst_i wins over lock: either one drops the sequence back to WAIT.
  assign w_abort  = sw_rst_i | ~w_lock_s;

  assign rst_o  = r_rst;
  assign done_o = r_done;

  // Lock synchroniser plus sequencing FSM; outputs are registered here so
  // nothing downstream sees a combinational path from any input.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_stage <= '0;
      r_sync  <= '0;
      r_rst   <= '1;
      r_done  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], lock_i};

      if ((r_state != S_WAIT) && w_abort) begin
        r_state <= S_WAIT;
        r_cnt   <= '0;
        r_stage <= '0;
        r_rst   <= '1;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT: begin
            r_rst  <= '1;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_stage <= '0;
            if (w_lock_s && !sw_rst_i) begin
              r_state <= S_HOLD;
            end
          end

          S_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
              r_cnt   <= '0;
              r_stage <= '0;
              // Channels fall strictly in index order, so a left shift with
              // zero fill clears exactly the next channel.
              r_rst   <= r_rst << 1;
              if (NUM_OUT == 1) begin
                r_state <= S_RUN;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_STAGE;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end

          S_STAGE: begin
            if (r_cnt == GAP_LAST) begin
              r_cnt   <= '0;
              r_stage <= r_stage + STW'(1);
              r_rst   <= r_rst << 1;
              if (r_stage == LAST_STAGE) begin
                r_state <= S_RUN;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end

          S_RUN: begin
            r_cnt  <= '0;
            r_rst  <= '0;
            r_done <= 1'b1;
          end

          default: begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_stage <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed scenarios followed by random lock / sw_rst / rst_n
// traffic, checked against a timing model that only tracks when the
// sequence started and derives each channel's release time arithmetically.

module tb_rst_seq;

  localparam int SYNC = 2;
  localparam int N_A  = 3;
  localparam int H_A  = 4;
  localparam int G_A  = 2;
  localparam int N_B  = 1;
  localparam int H_B  = 1;
  localparam int G_B  = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       lock_i;
  logic       sw_rst_i;
  logic [2:0] rst_a;
  logic       done_a;
  logic [0:0] rst_b;
  logic       done_b;

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  rst_seq #(.NUM_OUT(N_A), .HOLD_CYCLES(H_A), .STAGE_GAP(G_A), .SYNC_STAGES(SYNC)) dut_a (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .lock_i  (lock_i),
    .sw_rst_i(sw_rst_i),
    .rst_o   (rst_a),
    .done_o  (done_a)
  );

  rst_seq #(.NUM_OUT(N_B), .HOLD_CYCLES(H_B), .STAGE_GAP(G_B), .SYNC_STAGES(SYNC)) dut_b (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .lock_i  (lock_i),
    .sw_rst_i(sw_rst_i),
    .rst_o   (rst_b),
    .done_o  (done_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit            act_a = 1'b0;
  bit            act_b = 1'b0;
  int            t_a   = 0;
  int            t_b   = 0;
  logic [SYNC-1:0] hist = '0;
  bit            cause = 1'b1;
  logic [2:0]    prev_a = '1;
  logic [0:0]    prev_b = '1;

  // Channel k is released once (1 + H + k*G) cycles have elapsed since
  // the cycle in which lock was first seen in WAIT.
  function automatic logic [15:0] exp_rst(bit act, int el, int n, int h, int g);
    logic [15:0] v;
    v = '1;
    for (int k = 0; k < n; k++)
      if (act && (el >= 1 + h + k * g)) v[k] = 1'b0;
    return v;
  endfunction

  task automatic model_edge(input logic l, input logic s, input logic r);
    logic ls;
    ls    = hist[SYNC-1];
    cause = !r || !ls || s;
    if (!r) begin
      act_a = 1'b0;
      act_b = 1'b0;
      hist  = '0;
    end else begin
      if (act_a) begin
        if (!ls || s) act_a = 1'b0;
      end else if (ls && !s) begin
        act_a = 1'b1;
        t_a   = cyc;
      end
      if (act_b) begin
        if (!ls || s) act_b = 1'b0;
      end else if (ls && !s) begin
        act_b = 1'b1;
        t_b   = cyc;
      end
      hist = {hist[SYNC-2:0], l};
    end
    cyc++;
  endtask

  task automatic check_all();
    logic [15:0] e;
    logic [2:0]  ea;
    logic [0:0]  eb;
    logic        da;
    logic        db;
    logic        ok;
    e  = exp_rst(act_a, cyc - t_a, N_A, H_A, G_A);
    ea = e[2:0];
    e  = exp_rst(act_b, cyc - t_b, N_B, H_B, G_B);
    eb = e[0:0];
    da = act_a && ((cyc - t_a) >= 1 + H_A + (N_A - 1) * G_A);
    db = act_b && ((cyc - t_b) >= 1 + H_B + (N_B - 1) * G_B);

    checks++;
    assert (rst_a === ea) else begin
      errors++;
      $error("FAIL rst_a cyc=%0d got=%b exp=%b", cyc, rst_a, ea);
    end
    checks++;
    assert (done_a === da) else begin
      errors++;
      $error("FAIL done_a cyc=%0d got=%b exp=%b", cyc, done_a, da);
    end
    checks++;
    assert (rst_b === eb) else begin
      errors++;
      $error("FAIL rst_b cyc=%0d got=%b exp=%b", cyc, rst_b, eb);
    end
    checks++;
    assert (done_b === db) else begin
      errors++;
      $error("FAIL done_b cyc=%0d got=%b exp=%b", cyc, done_b, db);
    end

    ok = (((~prev_a & rst_a) == 3'b000) && ((~prev_b & rst_b) == 1'b0)) || cause;
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL rise_while_locked cyc=%0d got a=%b->%b b=%b->%b exp=no_rise",
             cyc, prev_a, rst_a, prev_b, rst_b);
    end
    prev_a = rst_a;
    prev_b = rst_b;
  endtask

  task automatic step(input logic l, input logic s, input logic r);
    lock_i   = l;
    sw_rst_i = s;
    rst_ni   = r;
    @(posedge clk_i);
    model_edge(l, s, r);
    #1;
    check_all();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    lock_i   = 1'b0;
    sw_rst_i = 1'b0;
    rst_ni   = 1'b0;

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_a", {1'b0, done_a, rst_a}, 4'b0111);
    chk("reset_b", {2'b00, done_b, rst_b}, 4'b0001);

    // Nominal release, loop index c is the cycle whose closing edge is stepped.
    for (int c = 0; c <= 12; c++) begin
      step(1'b1, 1'b0, 1'b1);
      case (c + 1)
        3:  chk("nom_b_c3", {2'b00, done_b, rst_b}, 4'b0001);
        4:  chk("nom_b_c4", {2'b00, done_b, rst_b}, 4'b0010);
        6:  chk("nom_c6", {1'b0, done_a, rst_a}, 4'b0111);
        7:  chk("nom_c7", {1'b0, done_a, rst_a}, 4'b0110);
        9:  chk("nom_c9", {1'b0, done_a, rst_a}, 4'b0100);
        11: chk("nom_c11", {1'b0, done_a, rst_a}, 4'b1000);
        default: ;
      endcase
    end

    // Lock loss in RUN for three cycles, then lock returns.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("loss_still_run", {1'b0, done_a, rst_a}, 4'b1000);
    step(1'b0, 1'b0, 1'b1);
    chk("loss_abort", {1'b0, done_a, rst_a}, 4'b0111);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);

    // One-cycle lock glitch during HOLD: nothing may release early.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("glitch_c0", {1'b0, done_a, rst_a}, 4'b0111);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("glitch_hold", {1'b0, done_a, rst_a}, 4'b0111);
    end
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1);

    // Software reset pulse while stage=1.
    step(1'b1, 1'b1, 1'b1);
    for (int j = 0; j <= 6; j++) step(1'b1, 1'b0, 1'b1);
    chk("sw_stage1", {1'b0, done_a, rst_a}, 4'b0100);
    step(1'b1, 1'b1, 1'b1);
    chk("sw_abort", {1'b0, done_a, rst_a}, 4'b0111);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);

    // Held software reset keeps everything in WAIT despite lock.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("sw_held", {1'b0, done_a, rst_a}, 4'b0111);
    end

    // Mid-sequence rst_ni pulse at cycle 8, then restart.
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      step(1'b1, 1'b0, (c == 8) ? 1'b0 : 1'b1);
      case (c + 1)
        8:  chk("mid_c8", {1'b0, done_a, rst_a}, 4'b0110);
        9:  chk("mid_c9", {1'b0, done_a, rst_a}, 4'b0111);
        15: chk("mid_c15", {1'b0, done_a, rst_a}, 4'b0111);
        16: chk("mid_c16", {1'b0, done_a, rst_a}, 4'b0110);
        default: ;
      endcase
    end

    // Random traffic: mostly locked, occasional drops, sw and rst_n pulses.
    for (int i = 0; i < 3000; i++) begin
      logic l;
      logic s;
      logic r;
      l = ($urandom_range(0, 99) < 96);
      s = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 299) != 0);
      step(l, s, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameters: NUM_OUT, default 3, number of reset output channels (legal 1..16).
REQ-002 Parameters: HOLD_CYCLES, default 16, cycles that all outputs stay asserted after the lock is seen (legal >= 1).
REQ-003 Parameters: STAGE_GAP, default 4, cycles between successive channel releases (legal >= 1).
REQ-004 Parameters: SYNC_STAGES, default 2, flip-flop depth of the lock_i synchroniser (legal >= 2).
REQ-005 Ports: clk_i  input  1  the single clock; all logic is clocked on its rising edge.
REQ-006 Ports: rst_ni  input  1  reset, synchronous and active-low.
REQ-007 Ports: lock_i  input  1  clock-source lock (e.g. PLL locked), asynchronous to clk_i.
REQ-008 Ports: sw_rst_i  input  1  software reset request, synchronous, level-sensitive, active-high.
REQ-009 Ports: rst_o  output  NUM_OUT  per-channel active-high reset, registered.
REQ-010 Ports: done_o  output  1  high when all channels are released, registered.

Function
REQ-011 The block SHALL pass lock_i through SYNC_STAGES flops; lock_s denotes the last flop output.
REQ-012 The FSM SHALL have three states: WAIT, HOLD and STAGE, plus RUN.
REQ-013 WAIT: all rst_o = 1; done_o = 0; if lock_s = 1 and sw_rst_i = 0, the next state SHALL be HOLD with cnt = 0.
REQ-014 HOLD: cnt SHALL increment each cycle; in the cycle where cnt = HOLD_CYCLES-1, the next state SHALL be STAGE, with stage = 0, cnt = 0, and rst_o[0] cleared.
REQ-015 STAGE: cnt SHALL increment each cycle; when cnt = STAGE_GAP-1, stage SHALL increment, rst_o[stage+1] SHALL be cleared, and cnt SHALL return to 0.
REQ-016 When the last channel is cleared, the next state SHALL be RUN and done_o SHALL rise in the same cycle as rst_o[NUM_OUT-1] falls.
REQ-017 If NUM_OUT = 1, HOLD SHALL go directly to RUN, with rst_o[0] cleared and done_o set in the same cycle.
REQ-018 Timing: if lock_s is first seen high in WAIT at cycle T, rst_o[k] SHALL be 0 from cycle T+1+HOLD_CYCLES+k*STAGE_GAP onward.
REQ-019 Released channels SHALL stay released; rst_o bits SHALL only ever fall in index order 0..NUM_OUT-1.
REQ-020 Abort: in HOLD, STAGE or RUN, if lock_s = 0 or sw_rst_i = 1, then on the next cycle all rst_o SHALL be 1, done_o SHALL be 0, cnt and stage SHALL be 0, and the state SHALL be WAIT.
REQ-021 While sw_rst_i = 1, the FSM SHALL remain in WAIT regardless of lock_s; sw_rst_i has priority over lock_s.
REQ-022 The counter width SHALL be $clog2(max(HOLD_CYCLES, STAGE_GAP))+1 bits; cnt SHALL never wrap, because it is cleared on every state change.
REQ-023 rst_o and done_o SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-024 While rst_ni = 0 at a clock edge, the block SHALL set: state = WAIT, cnt = 0, stage = 0, synchroniser flops = 0, rst_o = all 1, done_o = 0.
REQ-025 An rst_ni assertion in any state, including mid-STAGE, SHALL take effect at the next edge and SHALL override lock_i and sw_rst_i.
REQ-026 After rst_ni rises, the sequence SHALL restart from WAIT and need a fresh lock_s, which takes at least SYNC_STAGES cycles.

Verification (NUM_OUT=3, HOLD_CYCLES=4, STAGE_GAP=2, SYNC_STAGES=2)
REQ-027 Nominal: rst_ni high at cycle 0 and lock_i held high from cycle 0 (lock_s = 1 at T=2) -> rst_o = 3'b111 through cycle 6, 3'b110 at 7, 3'b100 at 9, 3'b000 and done_o = 1 at 11.
REQ-028 Lock loss: in RUN, drop lock_i for 3 cycles -> rst_o = 3'b111 and done_o = 0 SHALL follow lock_s = 0 by one cycle; on lock return the sequence SHALL repeat with the REQ-018 timing.
REQ-029 Glitch: a 1-cycle low on lock_i during HOLD -> full abort to WAIT; no rst_o bit SHALL release early.
REQ-030 Software reset: sw_rst_i pulsed 1 cycle during STAGE (stage=1) -> all rst_o = 1 next cycle; the restart SHALL follow the REQ-018 timing from the next lock_s-high cycle in WAIT.
REQ-031 Mid-sequence reset: rst_ni = 0 for 1 cycle at cycle 8 -> rst_o = 3'b111 at cycle 9; lock_s SHALL be 0 for 2 cycles, then the sequence SHALL restart.
REQ-032 Edge parameters: NUM_OUT=1 with HOLD_CYCLES=1 -> rst_o[0] and done_o SHALL change together 2 cycles after lock_s rises; a bench assertion SHALL check that no rst_o bit ever rises while lock_s = 1 and sw_rst_i = 0.
